alu_multicycle: RTL

//   Parametrised successor to the datapath ALU. Adds working SLL/SRL, an iterative
//   MUL (full 2*WIDTH product) and DIV (quotient + remainder), registered flags and
//   a valid/ready handshake so multi-cycle ops can stall the execute stage.

---
 rtl/alu_multicycle.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU: single-cycle logic/shift/add ops plus iterative MUL/DIV
// behind a valid/ready handshake. Define ALU_SIGNED_MULDIV_EN for signed MUL/DIV.
//   state | meaning
//   IDLE  | ready to accept an op
//   BUSY  | MUL/DIV iterating, one bit per cycle
//   HOLD  | result valid, waiting for outReady
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       opSel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resultHi,
  output logic             carryFlag,
  output logic             signFlag,
  output logic             zeroFlag,
  output logic             divZeroFlag
);

  localparam logic [3:0] OP_NOT   = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_XNOR  = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_NAND  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_ADD   = 4'd9;
  localparam logic [3:0] OP_SUB   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_PASSB = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e             state_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [SHW-1:0]     cnt_q;
  logic               divz_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   resulthi_q;
  logic               carry_q;
  logic               sign_q;
  logic               zero_q;
  logic               divzero_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               is_iter;

  assign is_iter = (opSel == OP_MUL) || (opSel == OP_DIV);

`ifdef ALU_SIGNED_MULDIV_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic neg_q;
  logic rneg_q;
  logic ovf_q;
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // Single-cycle datapath works on the live inputs; its result is captured at accept.
  logic [WIDTH:0]   sll_w;
  logic [WIDTH:0]   srl_w;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;

  always_comb begin
    sll_w    = {1'b0, a} << b[SHW-1:0];
    srl_w    = {a, 1'b0} >> b[SHW-1:0];
    add_w    = {1'b0, a} + {1'b0, b};
    sub_w    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    sc_res   = a;
    sc_carry = 1'b0;
    case (opSel)
      OP_NOT:   sc_res = ~a;
      OP_AND:   sc_res = a & b;
      OP_OR:    sc_res = a | b;
      OP_XOR:   sc_res = a ^ b;
      OP_XNOR:  sc_res = ~(a ^ b);
      OP_NOR:   sc_res = ~(a | b);
      OP_NAND:  sc_res = ~(a & b);
      OP_SLL: begin
        sc_res   = sll_w[WIDTH-1:0];
        sc_carry = sll_w[WIDTH];
      end
      OP_SRL: begin
        sc_res   = srl_w[WIDTH:1];
        sc_carry = srl_w[0];
      end
      OP_ADD: begin
        sc_res   = add_w[WIDTH-1:0];
        sc_carry = add_w[WIDTH];
      end
      OP_SUB: begin
        sc_res   = sub_w[WIDTH-1:0];
        sc_carry = ~sub_w[WIDTH];
      end
      OP_PASSB: sc_res = b;
      default:  sc_res = a;
    endcase
  end

  // One iteration: MUL shifts the partial product right, DIV shifts the
  // remainder/quotient pair left. The low half of acc holds the unconsumed operand.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, b_q};
    div_sub = div_sh[WIDTH-1:0] - b_q;
    if (op_q == OP_MUL) begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end else begin
      acc_d = {(div_ge ? div_sub : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end
  end

  // Final-cycle result is formed from the last iteration so MUL/DIV take WIDTH+1 cycles.
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;
  logic               fin_carry;
`ifdef ALU_SIGNED_MULDIV_EN
  logic [2*WIDTH-1:0] fin_prod;
`endif

  always_comb begin
`ifdef ALU_SIGNED_MULDIV_EN
    fin_prod = neg_q ? -acc_d : acc_d;
    if (op_q == OP_MUL) begin
      fin_lo    = fin_prod[WIDTH-1:0];
      fin_hi    = fin_prod[2*WIDTH-1:WIDTH];
      fin_carry = (fin_hi != '0);
    end else begin
      fin_lo    = divz_q ? '1 : (neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0]);
      fin_hi    = rneg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
      fin_carry = ovf_q;
    end
`else
    fin_hi = acc_d[2*WIDTH-1:WIDTH];
    if (op_q == OP_MUL) begin
      fin_lo    = acc_d[WIDTH-1:0];
      fin_carry = (fin_hi != '0);
    end else begin
      fin_lo    = divz_q ? '1 : acc_d[WIDTH-1:0];
      fin_carry = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      divz_q     <= 1'b0;
      result_q   <= '0;
      resulthi_q <= '0;
      carry_q    <= 1'b0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      divzero_q  <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inValid) begin
            op_q   <= opSel;
            a_q    <= a_mag;
            b_q    <= b_mag;
            divz_q <= (opSel == OP_DIV) && (b == '0);
`ifdef ALU_SIGNED_MULDIV_EN
            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            rneg_q <= a[WIDTH-1];
            ovf_q  <= (opSel == OP_DIV) && (a == MOST_NEG) && (b == '1);
`endif
            if (is_iter) begin
              acc_q   <= {{WIDTH{1'b0}}, ((opSel == OP_MUL) ? b_mag : a_mag)};
              cnt_q   <= SHW'(WIDTH - 1);
              state_q <= S_BUSY;
            end else begin
              result_q   <= sc_res;
              resulthi_q <= '0;
              carry_q    <= sc_carry;
              sign_q     <= sc_res[WIDTH-1];
              zero_q     <= (sc_res == '0);
              divzero_q  <= 1'b0;
              state_q    <= S_HOLD;
            end
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            result_q   <= fin_lo;
            resulthi_q <= fin_hi;
            carry_q    <= fin_carry;
            sign_q     <= fin_lo[WIDTH-1];
            zero_q     <= (fin_lo == '0);
            divzero_q  <= divz_q;
            state_q    <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - SHW'(1);
          end
        end
        S_HOLD: begin
          if (outReady) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inReady     = rstN && (state_q == S_IDLE);
  assign outValid    = (state_q == S_HOLD);
  assign result      = result_q;
  assign resultHi    = resulthi_q;
  assign carryFlag   = carry_q;
  assign signFlag    = sign_q;
  assign zeroFlag    = zero_q;
  assign divZeroFlag = divzero_q;

endmodule
